// File: rtl/lcd_hd44780_ctrl_if.sv
// lcd_hd44780_ctrl_if: byte command handshake between a requester and the LCD controller
interface lcd_hd44780_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_rs;
   logic [7:0] cmd_data;
   modport master (output cmd_valid, cmd_rs, cmd_data, input cmd_ready);
   modport slave (input cmd_valid, cmd_rs, cmd_data, output cmd_ready);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: HD44780 8-bit bus sequencer with power-up init, timed write phases and busy-flag polling
module lcd_hd44780_ctrl #(
   parameter int T_AS        = 3,
   parameter int T_PW        = 12,
   parameter int T_H         = 2,
   parameter int T_GAP       = 13,
   parameter int POWERUP_CYC = 750000,
   parameter int INIT_GAP    = 250000,
   parameter int POLL_MAX    = 1024,
   parameter int CNT_W       = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   lcd_hd44780_ctrl_if.slave        cmd,
   output logic                     init_done,
   output logic                     busy_timeout,
   output logic                     LCD_E,
   output logic                     LCD_RS,
   output logic                     LCD_RW,
   output logic [7:0]               LCD_data_out,
   output logic                     LCD_data_oe,
   input  logic [7:0]               LCD_data_in
);
   localparam int PC_W = $clog2(POLL_MAX + 1);
   localparam logic [CNT_W-1:0] C_AS  = CNT_W'(T_AS - 1);
   localparam logic [CNT_W-1:0] C_PW  = CNT_W'(T_PW - 1);
   localparam logic [CNT_W-1:0] C_H   = CNT_W'(T_H - 1);
   localparam logic [CNT_W-1:0] C_GAP = CNT_W'(T_GAP - 1);
   localparam logic [CNT_W-1:0] C_IG  = CNT_W'(INIT_GAP - 1);
   localparam logic [CNT_W-1:0] C_PU  = CNT_W'(POWERUP_CYC - 1);

   typedef enum logic [2:0] {POWERUP, INIT, IDLE, WRITE, POLL} state_t;
   typedef enum logic [2:0] {LATCH, SETUP, PULSE, HOLD, GAP} phase_t;

   state_t            state;
   phase_t            phase;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        idx;
   logic [PC_W-1:0]   polls;
   logic              bf;
   logic              lat_rs;
   logic [7:0]        lat_data;
   logic              last;
   logic              go;
   logic              acc_rs;
   logic              acc_rw;
   logic [7:0]        acc_d;
   logic              data_in_unused;

   function automatic logic [7:0] rom(input logic [2:0] i);
      return i == 3'd3 ? 8'h0C : i == 3'd4 ? 8'h01 : i == 3'd5 ? 8'h06 : 8'h38;
   endfunction

   assign data_in_unused = ^LCD_data_in[6:0];
   assign last = cnt == '0;

   // decide when a new access begins and what RS/RW/data it drives
   always_comb begin
      go = (state == POWERUP && last) || (state == WRITE && phase == LATCH) ||
           (phase == GAP && last && (state == INIT ? idx != 3'd5 :
            state == WRITE || (state == POLL && bf && polls != PC_W'(POLL_MAX - 1))));
      acc_rw = (state == WRITE && phase != LATCH) || state == POLL;
      acc_rs = state == WRITE && phase == LATCH && lat_rs;
      acc_d  = state == WRITE ? lat_data : rom(state == INIT ? idx + 3'd1 : 3'd0);
   end

   // top-level FSM and access-phase engine, all outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= POWERUP;
         phase         <= SETUP;
         cnt           <= C_PU;
         idx           <= '0;
         polls         <= '0;
         bf            <= 1'b0;
         lat_rs        <= 1'b0;
         lat_data      <= '0;
         init_done     <= 1'b0;
         busy_timeout  <= 1'b0;
         cmd.cmd_ready <= 1'b0;
         LCD_E         <= 1'b0;
         LCD_RS        <= 1'b0;
         LCD_RW        <= 1'b0;
         LCD_data_out  <= '0;
         LCD_data_oe   <= 1'b0;
      end else begin
         if (go) begin
            phase        <= SETUP;
            cnt          <= C_AS;
            LCD_RS       <= acc_rs;
            LCD_RW       <= acc_rw;
            LCD_data_oe  <= !acc_rw;
            LCD_data_out <= acc_d;
         end
         if (state == IDLE) begin
            if (cmd.cmd_valid && cmd.cmd_ready) begin
               state         <= WRITE;
               phase         <= LATCH;
               lat_rs        <= cmd.cmd_rs;
               lat_data      <= cmd.cmd_data;
               polls         <= '0;
               cmd.cmd_ready <= 1'b0;
            end
         end else if (state == POWERUP) begin
            if (last) state <= INIT;
            else cnt <= cnt - 1'b1;
         end else if (phase != LATCH) begin
            if (!last) cnt <= cnt - 1'b1;
            else if (phase == SETUP) begin
               phase <= PULSE;
               cnt   <= C_PW;
               LCD_E <= 1'b1;
            end else if (phase == PULSE) begin
               phase <= HOLD;
               cnt   <= C_H;
               LCD_E <= 1'b0;
               bf    <= LCD_data_in[7];
            end else if (phase == HOLD) begin
               phase       <= GAP;
               cnt         <= state == INIT ? C_IG : C_GAP;
               LCD_data_oe <= 1'b0;
            end else if (state == INIT) begin
               if (idx == 3'd5) begin
                  state         <= IDLE;
                  init_done     <= 1'b1;
                  cmd.cmd_ready <= 1'b1;
               end else idx <= idx + 3'd1;
            end else if (state == WRITE) state <= POLL;
            else if (!bf) begin
               state         <= IDLE;
               cmd.cmd_ready <= 1'b1;
            end else if (polls == PC_W'(POLL_MAX - 1)) begin
               state         <= IDLE;
               busy_timeout  <= 1'b1;
               cmd.cmd_ready <= 1'b1;
            end else polls <= polls + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb_lcd_hd44780_ctrl: directed vector bench for the HD44780 sequencer with a busy-flag LCD model
module tb_lcd_hd44780_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       init_done, busy_timeout, LCD_E, LCD_RS, LCD_RW, LCD_data_oe;
   logic [7:0] LCD_data_out, LCD_data_in;

   typedef struct {
      logic       rs, rw, oe;
      logic [7:0] data;
      int         setup, width, hold;
   } pulse_t;
   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         bf, polls, low;
      logic       to;
   } vec_t;

   pulse_t      pl [16];
   vec_t        vt [5];
   int          np, nhs, contention, bf_left, stable;
   int          nvec, nerr;
   logic        prev_e = 1'b0;
   logic        holding = 1'b0;
   logic [10:0] sig, prev_sig, snap;

   lcd_hd44780_ctrl_if cmd_if ();

   lcd_hd44780_ctrl #(.POWERUP_CYC(100), .INIT_GAP(50), .POLL_MAX(4)) dut (
      .clk(clk), .reset(reset), .cmd(cmd_if), .init_done(init_done), .busy_timeout(busy_timeout),
      .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_data_out(LCD_data_out),
      .LCD_data_oe(LCD_data_oe), .LCD_data_in(LCD_data_in)
   );

   assign LCD_data_in = {bf_left != 0, 7'h00};

   always #5 clk = ~clk;

   // bus monitor: records each E pulse, counts handshakes, models BF, flags oe/RW overlap
   always @(negedge clk) begin
      sig = {LCD_RS, LCD_RW, LCD_data_oe, LCD_data_out};
      assert (!(LCD_data_oe && LCD_RW)) else begin
         contention++;
         $display("FAIL contention: oe=%b rw=%b required not both 1", LCD_data_oe, LCD_RW);
      end
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) nhs++;
      if (LCD_E && !prev_e) begin
         if (np < 16) pl[np] = '{LCD_RS, LCD_RW, LCD_data_oe, LCD_data_out, stable, 0, 0};
         snap = sig;
         np++;
      end
      if (LCD_E && np > 0 && np <= 16) pl[np-1].width++;
      if (!LCD_E && prev_e) holding = 1'b1;
      if (!LCD_E && holding) begin
         if (sig == snap && np > 0 && np <= 16) pl[np-1].hold++;
         else holding = 1'b0;
      end
      if (!LCD_E && prev_e && LCD_RW && bf_left > 0) bf_left--;
      stable = (!LCD_E && sig == prev_sig) ? stable + 1 : 1;
      prev_e = LCD_E;
      prev_sig = sig;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wait_sig(input int sel, input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(sel == 0 ? LCD_E : sel == 1 ? init_done : cmd_if.cmd_ready) && n < limit);
   endtask

   task automatic powerup_check(input string tag);
      int n1, n2;
      logic [7:0] rom [6];
      rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      np = 0;
      wait_sig(0, 1000, n1);
      check({tag, "_first_e"}, n1, 103);
      wait_sig(1, 1000, n2);
      check({tag, "_init_done_at"}, n1 + n2, 502);
      check({tag, "_ready_with_done"}, cmd_if.cmd_ready, 1);
      check({tag, "_init_pulses"}, np, 6);
      for (int i = 0; i < 6; i++)
         check({tag, "_init_byte"}, {pl[i].rs, pl[i].rw, pl[i].oe, pl[i].data}, {3'b001, rom[i]});
   endtask

   // stimulus: reset, init, table of commands, mid-pulse reset, back-to-back stream
   initial begin
      int n, low, bad;
      logic [7:0] bytes [3];
      vt[0] = '{1'b1, 8'h41, 0, 1, 61, 1'b0};
      vt[1] = '{1'b0, 8'h01, 3, 4, 151, 1'b0};
      vt[2] = '{1'b1, 8'h5A, 9, 4, 151, 1'b1};
      vt[3] = '{1'b1, 8'h42, 0, 1, 61, 1'b1};
      vt[4] = '{1'b0, 8'h80, 1, 2, 91, 1'b1};
      bytes = '{8'h31, 8'h32, 8'h33};
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_rs = 1'b0;
      cmd_if.cmd_data = '0;
      bf_left = 0;
      repeat (5) tick();
      check("reset_outputs", {init_done, busy_timeout, LCD_E, LCD_RS, LCD_RW, LCD_data_oe,
                              LCD_data_out, cmd_if.cmd_ready}, 0);
      reset = 1'b0;
      powerup_check("pwr");
      for (int i = 0; i < 5; i++) begin
         bf_left = vt[i].bf;
         np = 0;
         cmd_if.cmd_valid = 1'b1;
         cmd_if.cmd_rs = vt[i].rs;
         cmd_if.cmd_data = vt[i].data;
         tick();
         check("ready_drop", cmd_if.cmd_ready, 0);
         cmd_if.cmd_valid = 1'b0;
         wait_sig(2, 2000, low);
         check("ready_low", low, vt[i].low);
         check("pulses", np, 1 + vt[i].polls);
         check("write_bus", {pl[0].rs, pl[0].rw, pl[0].oe, pl[0].data}, {vt[i].rs, 2'b01, vt[i].data});
         check("write_setup", pl[0].setup, 3);
         check("write_width", pl[0].width, 12);
         check("write_hold", pl[0].hold, 2);
         bad = 0;
         for (int k = 1; k < np && k < 16; k++)
            if ({pl[k].rs, pl[k].rw, pl[k].oe} != 3'b010 || pl[k].width != 12) bad++;
         check("poll_bus", bad, 0);
         check("busy_timeout", busy_timeout, vt[i].to);
      end
      bf_left = 0;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_rs = 1'b1;
      cmd_if.cmd_data = 8'h55;
      tick();
      cmd_if.cmd_valid = 1'b0;
      wait_sig(0, 100, n);
      tick();
      tick();
      check("mid_pulse_e", LCD_E, 1);
      reset = 1'b1;
      tick();
      check("mid_reset_state", {LCD_E, cmd_if.cmd_ready, init_done, busy_timeout}, 0);
      reset = 1'b0;
      powerup_check("rst2");
      np = 0;
      nhs = 0;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_rs = 1'b1;
      for (int j = 0; j < 3; j++) begin
         cmd_if.cmd_data = bytes[j];
         n = 0;
         while (!cmd_if.cmd_ready && n < 500) begin
            tick();
            n++;
         end
         tick();
      end
      cmd_if.cmd_valid = 1'b0;
      wait_sig(2, 500, n);
      check("b2b_handshakes", nhs, 3);
      check("b2b_pulses", np, 6);
      for (int j = 0; j < 3; j++)
         check("b2b_data", {pl[2*j].rw, pl[2*j].data}, {1'b0, bytes[j]});
      check("no_contention", contention, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
Timing sequencer for the character-LCD bus (HD44780-compatible, 8-bit mode) on the DE2-115. It replaces software bit-banging of the raw LCD port: it runs the power-up init sequence, accepts byte commands and data from a simple valid/ready interface, and generates correctly timed RS/RW/E/data phases. After every normal write it polls the busy flag. It sits between the SOPC command path and the LCD_* pins.

Parameters:
T_AS, 3, cycles RS/RW/data valid before E rises (>=40 ns at 50 MHz)
T_PW, 12, cycles E held high (>=230 ns)
T_H, 2, cycles RS/RW/data held after E falls
T_GAP, 13, cycles E low before the next access may start (E cycle >=500 ns)
POWERUP_CYC, 750000, cycles of idle after reset before the first init write (15 ms)
INIT_GAP, 250000, fixed wait after each init write (no busy poll during init)
POLL_MAX, 1024, busy polls per command before abort
CNT_W, 20, timing-counter width; must hold max(POWERUP_CYC, INIT_GAP)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command/data byte offered
cmd_ready  out  1  controller can accept a byte this cycle
cmd_rs  in  1  0 = instruction register, 1 = data register
cmd_data  in  8  byte to write
init_done  out  1  init sequence complete; stays high until reset
busy_timeout  out  1  sticky; set when POLL_MAX is exceeded; cleared only by reset
LCD_E  out  1  enable strobe
LCD_RS  out  1  register select
LCD_RW  out  1  0 = write, 1 = read
LCD_data_out  out  8  data driven to the pad
LCD_data_oe  out  1  pad output enable; the top level builds the inout from this
LCD_data_in  in  8  pad input; bit 7 is the busy flag

Behaviour:
- Single clock domain. All outputs are registered.
- Reset values: every output is 0. Reset asserted mid-access forces LCD_E low on the next edge and restarts at POWERUP.
- Clocking: one down-counter of CNT_W bits times every phase. A phase of N cycles holds its outputs for exactly N clocks.
- Top-level FSM states: POWERUP, INIT, IDLE, WRITE, POLL.
- POWERUP: wait POWERUP_CYC cycles, then go to INIT.
- INIT: write ROM bytes 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order, all with RS=0. After each byte wait INIT_GAP cycles. After the last byte, set init_done and go to IDLE.
- IDLE: cmd_ready=1 only in IDLE with init_done=1. A handshake is cmd_valid && cmd_ready. On a handshake, latch cmd_rs/cmd_data, drop cmd_ready on the next cycle, and go to WRITE.
- Access engine (shared by WRITE, INIT and POLL) has four phases:
  - SETUP, T_AS cycles: E=0, RS/RW set, and for writes oe=1 and data driven.
  - PULSE, T_PW cycles: E=1.
  - HOLD, T_H cycles: E=0, RS/RW/data/oe unchanged.
  - GAP, T_GAP cycles: oe=0 and E=0.
- WRITE: RW=0, RS=latched, data=latched. When GAP ends, go to POLL.
- POLL: RS=0, RW=1, oe=0.
  - Sample LCD_data_in[7] in the last PULSE cycle.
  - After GAP: if BF=0, return to IDLE.
  - If BF=1, increment the poll count. If poll count == POLL_MAX, set busy_timeout and return to IDLE; otherwise repeat POLL.
  - The poll count clears on every new command.
- Bus-contention rule: oe and RW=1 are never both high in the same cycle. RW changes only while E=0.
- Throughput: a command with BF=0 on the first poll holds cmd_ready low for 2*(T_AS+T_PW+T_H+T_GAP)+1 cycles (61 with defaults). cmd_ready rises in the cycle after the final GAP cycle.
- cmd_valid while cmd_ready=0 is ignored and does not stall the FSM. The requester must hold cmd_valid and its data stable until the handshake.
- After busy_timeout is set, commands continue to be accepted and executed normally.

Test Plan:
- Reset/power-up (POWERUP_CYC=100, INIT_GAP=50): hold reset 5 cycles → all outputs 0. Then exactly 6 E pulses with data 38,38,38,0C,01,06 and RS=0. init_done rises after the 6th INIT_GAP and cmd_ready rises the same cycle.
- Single data write: cmd_rs=1, cmd_data=0x41, LCD model BF=0 → RS=1/RW=0/data 0x41 stable 3 cycles before E. E high exactly 12 cycles. Data held 2 cycles after E falls. One poll follows. cmd_ready is low 61 cycles.
- Busy wait: model BF=1 for 3 polls, then 0 → 4 poll E pulses after the write, busy_timeout stays 0, and cmd_ready returns after the 4th poll.
- Timeout (POLL_MAX=4): BF stuck at 1 → exactly 4 polls, busy_timeout=1, IDLE reached. A next write of 0x42 is still issued.
- Reset mid-PULSE of a write: E=0 on the next cycle, cmd_ready=0, init_done=0, and the POWERUP count restarts from full.
- Back-to-back cmd_valid held high with 3 bytes → 3 handshakes, each only when cmd_ready=1. No overlap of oe with RW=1, asserted every cycle by a bench assertion.
